alu_pipe: RTL



---
 rtl/alu_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshaking and backpressure on both sides.
// Define ALU_CARRY_CHAIN_EN to take the ADD_c/SUB_b carry from an internal sticky flag instead of cin.
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       ctl,
    output logic             valid_out,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu,
    output logic             carry,
    output logic             zero,
    output logic             err
);
    typedef enum logic [3:0] {
        OP_SEL  = 4'd0,  OP_INC  = 4'd1,  OP_DEC  = 4'd2,  OP_ADD  = 4'd3,
        OP_ADDC = 4'd4,  OP_SUB  = 4'd5,  OP_SUBB = 4'd6,  OP_AND  = 4'd7,
        OP_OR   = 4'd8,  OP_XOR  = 4'd9,  OP_SHL  = 4'd10, OP_SHR  = 4'd11,
        OP_ROL  = 4'd12, OP_ROR  = 4'd13
    } op_e;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    // Result packed as {err, carry, alu}; bit WIDTH of the (WIDTH+1)-bit result is the carry/borrow.
    function automatic logic [WIDTH+1:0] alu_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c,
                                                input logic [3:0]       op);
        logic [WIDTH:0] xe, ye, ce, r;
        logic           e;
        xe = {1'b0, x};
        ye = {1'b0, y};
        ce = {{WIDTH{1'b0}}, c};
        r  = '0;
        e  = 1'b0;
        case (op)
            OP_SEL:  r = ye;
            OP_INC:  r = ye + ONE;
            OP_DEC:  r = ye - ONE;
            OP_ADD:  r = xe + ye;
            OP_ADDC: r = xe + ye + ce;
            OP_SUB:  r = xe - ye;
            OP_SUBB: r = xe - ye - ce;
            OP_AND:  r = xe & ye;
            OP_OR:   r = xe | ye;
            OP_XOR:  r = xe ^ ye;
            OP_SHL:  r = {x, 1'b0};
            OP_SHR:  r = {x[0], 1'b0, x[WIDTH-1:1]};
            OP_ROL:  r = {1'b0, x[WIDTH-2:0], x[WIDTH-1]};
            OP_ROR:  r = {1'b0, x[0], x[WIDTH-1:1]};
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] a_p1_q, b_p1_q;
    logic [3:0]       ctl_p1_q;
    logic             c_p1;
    logic [WIDTH+1:0] res_p1;
    logic             s1_load, s2_load;

    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] alu_p2_q;
    logic             carry_p2_q, zero_p2_q, err_p2_q;

    assign s2_load  = vld_p1_q && (!vld_p2_q || out_ready);
    assign in_ready = !reset && (!vld_p1_q || s2_load);
    assign s1_load  = valid_in && in_ready;

    always_comb begin
        vld_p1_d = vld_p1_q;
        if (s1_load)      vld_p1_d = 1'b1;
        else if (s2_load) vld_p1_d = 1'b0;
        vld_p2_d = vld_p2_q;
        if (s2_load)        vld_p2_d = 1'b1;
        else if (out_ready) vld_p2_d = 1'b0;
    end

    // ---- Stage 1: operand capture ----
    always_ff @(posedge clk) begin
        if (reset) vld_p1_q <= 1'b0;
        else       vld_p1_q <= vld_p1_d;
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            a_p1_q   <= a;
            b_p1_q   <= b;
            ctl_p1_q <= ctl;
        end
    end

`ifdef ALU_CARRY_CHAIN_EN
    logic cflag_q, cflag_d;

    // The flag is written in S2-load order, so an ADD directly followed by ADD_c chains with no bubble.
    always_comb begin
        cflag_d = cflag_q;
        if (s2_load && (ctl_p1_q inside {OP_INC, OP_DEC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBB, OP_SHL, OP_SHR}))
            cflag_d = res_p1[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) cflag_q <= 1'b0;
        else       cflag_q <= cflag_d;
    end

    assign c_p1 = cflag_q;
`else
    logic cin_p1_q;

    always_ff @(posedge clk) begin
        if (s1_load) cin_p1_q <= cin;
    end

    assign c_p1 = cin_p1_q;
`endif

    assign res_p1 = alu_op(a_p1_q, b_p1_q, c_p1, ctl_p1_q);

    // ---- Stage 2: compute and result register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2_q   <= 1'b0;
            alu_p2_q   <= '0;
            carry_p2_q <= 1'b0;
            zero_p2_q  <= 1'b0;
            err_p2_q   <= 1'b0;
        end else begin
            vld_p2_q <= vld_p2_d;
            if (s2_load) begin
                alu_p2_q   <= res_p1[WIDTH-1:0];
                carry_p2_q <= res_p1[WIDTH];
                zero_p2_q  <= (res_p1[WIDTH-1:0] == '0);
                err_p2_q   <= res_p1[WIDTH+1];
            end
        end
    end

    assign valid_out = vld_p2_q;
    assign alu       = alu_p2_q;
    assign carry     = carry_p2_q;
    assign zero      = zero_p2_q;
    assign err       = err_p2_q;
endmodule
